mem_arbiter: RTL and testbench

Two-requester arbiter that shares one cache instance (pulse request / pulse response interface) between the core's instruction-fetch port and data-access port. Each requester issues a one-cycle request pulse. The arbiter latches it, serialises requests to the cache one at a time, and routes the cache's one-cycle response pulse and data back to the owning requester. It sits between the core pipeline and the cache wrapper.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and cache pulse-handshake bundle.
// slave = arbiter side, master = core requesters + cache side.
interface mem_arbiter_if;
  logic        f_request_enable;
  logic [31:0] f_req_addr;
  logic        f_response_enable;
  logic [31:0] f_resp_data;
  logic        d_request_enable;
  logic        d_req_mode;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_wstrb;
  logic        d_response_enable;
  logic [31:0] d_resp_data;
  logic        c_request_enable;
  logic        c_req_mode;
  logic [31:0] c_req_addr;
  logic [31:0] c_req_wdata;
  logic [3:0]  c_req_wstrb;
  logic        c_response_enable;
  logic [31:0] c_resp_data;

  modport slave (
    input  f_request_enable, f_req_addr,
    input  d_request_enable, d_req_mode,
    input  d_req_addr, d_req_wdata, d_req_wstrb,
    input  c_response_enable, c_resp_data,
    output f_response_enable, f_resp_data,
    output d_response_enable, d_resp_data,
    output c_request_enable, c_req_mode,
    output c_req_addr, c_req_wdata, c_req_wstrb
  );

  modport master (
    output f_request_enable, f_req_addr,
    output d_request_enable, d_req_mode,
    output d_req_addr, d_req_wdata, d_req_wstrb,
    output c_response_enable, c_resp_data,
    input  f_response_enable, f_resp_data,
    input  d_response_enable, d_resp_data,
    input  c_request_enable, c_req_mode,
    input  c_req_addr, c_req_wdata, c_req_wstrb
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one cache between fetch and data ports.
// Ports: clk, rstn (async low), bus (mem_arbiter_if.slave).
module mem_arbiter #(
  parameter bit RR_ENABLE = 1'b1
) (
  input logic          clk,
  input logic          rstn,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  state_e      state_q, state_d;
  logic        f_pend_q, f_pend_d;
  logic        d_pend_q, d_pend_d;
  logic [31:0] f_addr_q, f_addr_d;
  logic        d_mode_q, d_mode_d;
  logic [31:0] d_addr_q, d_addr_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic [3:0]  d_wstrb_q, d_wstrb_d;
  // 1 = data port owns the cache
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        c_en_q, c_en_d;
  logic        c_mode_q, c_mode_d;
  logic [31:0] c_addr_q, c_addr_d;
  logic [31:0] c_wdata_q, c_wdata_d;
  logic [3:0]  c_wstrb_q, c_wstrb_d;
  logic        f_rsp_q, f_rsp_d;
  logic [31:0] f_rdata_q, f_rdata_d;
  logic        d_rsp_q, d_rsp_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        f_set, d_set;

  // a pulse on a port already pending is dropped
  assign f_set = bus.f_request_enable && !f_pend_q;
  assign d_set = bus.d_request_enable && !d_pend_q;

  always_comb begin
    state_d   = state_q;
    f_pend_d  = f_pend_q;
    d_pend_d  = d_pend_q;
    f_addr_d  = f_addr_q;
    d_mode_d  = d_mode_q;
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    d_wstrb_d = d_wstrb_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    c_en_d    = 1'b0;
    c_mode_d  = c_mode_q;
    c_addr_d  = c_addr_q;
    c_wdata_d = c_wdata_q;
    c_wstrb_d = c_wstrb_q;
    f_rsp_d   = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rsp_d   = 1'b0;
    d_rdata_d = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (f_pend_q || d_pend_q) begin
          if (f_pend_q && d_pend_q)
            gnt_d = RR_ENABLE ? !last_q : 1'b1;
          else
            gnt_d = d_pend_q;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        c_en_d    = 1'b1;
        c_mode_d  = gnt_q & d_mode_q;
        c_addr_d  = gnt_q ? d_addr_q : f_addr_q;
        c_wdata_d = gnt_q ? d_wdata_q : '0;
        c_wstrb_d = gnt_q ? d_wstrb_q : '0;
        last_d    = gnt_q;
        state_d   = WAIT;
      end
      WAIT: begin
        if (bus.c_response_enable) begin
          if (gnt_q) begin
            d_rsp_d   = 1'b1;
            d_rdata_d = bus.c_resp_data;
            d_pend_d  = 1'b0;
          end else begin
            f_rsp_d   = 1'b1;
            f_rdata_d = bus.c_resp_data;
            f_pend_d  = 1'b0;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // capture last so a set beats a clear on the same edge
    if (f_set) begin
      f_pend_d = 1'b1;
      f_addr_d = bus.f_req_addr;
    end
    if (d_set) begin
      d_pend_d  = 1'b1;
      d_mode_d  = bus.d_req_mode;
      d_addr_d  = bus.d_req_addr;
      d_wdata_d = bus.d_req_wdata;
      d_wstrb_d = bus.d_req_wstrb;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      f_pend_q  <= 1'b0;
      d_pend_q  <= 1'b0;
      f_addr_q  <= '0;
      d_mode_q  <= 1'b0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      d_wstrb_q <= '0;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      c_en_q    <= 1'b0;
      c_mode_q  <= 1'b0;
      c_addr_q  <= '0;
      c_wdata_q <= '0;
      c_wstrb_q <= '0;
      f_rsp_q   <= 1'b0;
      f_rdata_q <= '0;
      d_rsp_q   <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      f_pend_q  <= f_pend_d;
      d_pend_q  <= d_pend_d;
      f_addr_q  <= f_addr_d;
      d_mode_q  <= d_mode_d;
      d_addr_q  <= d_addr_d;
      d_wdata_q <= d_wdata_d;
      d_wstrb_q <= d_wstrb_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      c_en_q    <= c_en_d;
      c_mode_q  <= c_mode_d;
      c_addr_q  <= c_addr_d;
      c_wdata_q <= c_wdata_d;
      c_wstrb_q <= c_wstrb_d;
      f_rsp_q   <= f_rsp_d;
      f_rdata_q <= f_rdata_d;
      d_rsp_q   <= d_rsp_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.c_request_enable  = c_en_q;
  assign bus.c_req_mode        = c_mode_q;
  assign bus.c_req_addr        = c_addr_q;
  assign bus.c_req_wdata       = c_wdata_q;
  assign bus.c_req_wstrb       = c_wstrb_q;
  assign bus.f_response_enable = f_rsp_q;
  assign bus.f_resp_data       = f_rdata_q;
  assign bus.d_response_enable = d_rsp_q;
  assign bus.d_resp_data       = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: round-robin and fixed-priority arbiters
// driven side by side, checked against an edge-timeline model.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus_rr ();
  mem_arbiter_if bus_fp ();

  mem_arbiter #(.RR_ENABLE(1'b1)) u_rr (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_rr)
  );
  mem_arbiter #(.RR_ENABLE(1'b0)) u_fp (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_fp)
  );

  logic        f_en = 1'b0;
  logic [31:0] f_addr = '0;
  logic        d_en = 1'b0;
  logic        d_mode = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        cr_en [2];
  logic [31:0] cr_data [2];

  assign bus_rr.f_request_enable  = f_en;
  assign bus_rr.f_req_addr        = f_addr;
  assign bus_rr.d_request_enable  = d_en;
  assign bus_rr.d_req_mode        = d_mode;
  assign bus_rr.d_req_addr        = d_addr;
  assign bus_rr.d_req_wdata       = d_wdata;
  assign bus_rr.d_req_wstrb       = d_wstrb;
  assign bus_rr.c_response_enable = cr_en[0];
  assign bus_rr.c_resp_data       = cr_data[0];
  assign bus_fp.f_request_enable  = f_en;
  assign bus_fp.f_req_addr        = f_addr;
  assign bus_fp.d_request_enable  = d_en;
  assign bus_fp.d_req_mode        = d_mode;
  assign bus_fp.d_req_addr        = d_addr;
  assign bus_fp.d_req_wdata       = d_wdata;
  assign bus_fp.d_req_wstrb       = d_wstrb;
  assign bus_fp.c_response_enable = cr_en[1];
  assign bus_fp.c_resp_data       = cr_data[1];

  logic        a_cen [2];
  logic        a_cmode [2];
  logic [31:0] a_caddr [2];
  logic [31:0] a_cwd [2];
  logic [3:0]  a_cws [2];
  logic        a_fre [2];
  logic [31:0] a_frd [2];
  logic        a_dre [2];
  logic [31:0] a_drd [2];

  assign a_cen[0]   = bus_rr.c_request_enable;
  assign a_cmode[0] = bus_rr.c_req_mode;
  assign a_caddr[0] = bus_rr.c_req_addr;
  assign a_cwd[0]   = bus_rr.c_req_wdata;
  assign a_cws[0]   = bus_rr.c_req_wstrb;
  assign a_fre[0]   = bus_rr.f_response_enable;
  assign a_frd[0]   = bus_rr.f_resp_data;
  assign a_dre[0]   = bus_rr.d_response_enable;
  assign a_drd[0]   = bus_rr.d_resp_data;
  assign a_cen[1]   = bus_fp.c_request_enable;
  assign a_cmode[1] = bus_fp.c_req_mode;
  assign a_caddr[1] = bus_fp.c_req_addr;
  assign a_cwd[1]   = bus_fp.c_req_wdata;
  assign a_cws[1]   = bus_fp.c_req_wstrb;
  assign a_fre[1]   = bus_fp.f_response_enable;
  assign a_frd[1]   = bus_fp.f_resp_data;
  assign a_dre[1]   = bus_fp.d_response_enable;
  assign a_drd[1]   = bus_fp.d_resp_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cen_cnt [2];
  string pfx [2];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- cache responder ----------------
  int          cdelay = 3;
  bit          stray_en = 1'b0;
  bit          fix_data = 1'b1;
  logic [31:0] fix_rdata = '0;
  int          ccnt [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      cr_en[k]   = 1'b0;
      cr_data[k] = '0;
      ccnt[k]    = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        cr_en[k] = 1'b0;
        if (ccnt[k] > 0) begin
          ccnt[k]--;
          if (ccnt[k] == 0) begin
            cr_en[k]   = 1'b1;
            cr_data[k] = fix_data ? fix_rdata : $urandom;
          end
        end
        if (a_cen[k]) begin
          ccnt[k] = (cdelay > 0) ? cdelay : int'($urandom_range(5, 1));
        end else if (stray_en && ccnt[k] == 0 && !cr_en[k] &&
                     $urandom_range(7, 0) == 0) begin
          cr_en[k]   = 1'b1;
          cr_data[k] = $urandom;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Edge-numbered timeline: a grant decided at edge g pulses the
  // cache after edge g+1; responses count from edge g+2 onward.
  bit          m_pend [2][2];
  logic [31:0] m_addr [2][2];
  logic        m_mode [2];
  logic [31:0] m_wd [2];
  logic [3:0]  m_ws [2];
  int          m_own [2];
  int          m_gedge [2];
  bit          m_last [2];
  int          nedge = 0;

  logic        e_cen [2];
  logic        e_cmode [2];
  logic [31:0] e_caddr [2];
  logic [31:0] e_cwd [2];
  logic [3:0]  e_cws [2];
  logic        e_fre [2];
  logic [31:0] e_frd [2];
  logic        e_dre [2];
  logic [31:0] e_drd [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k][0] = 1'b0;
      m_pend[k][1] = 1'b0;
      m_own[k]     = -1;
      m_gedge[k]   = 0;
      m_last[k]    = 1'b1;
      e_cen[k]     = 1'b0;
      e_cmode[k]   = 1'b0;
      e_caddr[k]   = '0;
      e_cwd[k]     = '0;
      e_cws[k]     = '0;
      e_fre[k]     = 1'b0;
      e_frd[k]     = '0;
      e_dre[k]     = 1'b0;
      e_drd[k]     = '0;
    end
  endtask

  task automatic model_step();
    bit po0, po1;
    int oo;
    nedge++;
    for (int k = 0; k < 2; k++) begin
      po0 = m_pend[k][0];
      po1 = m_pend[k][1];
      oo  = m_own[k];
      e_cen[k] = 1'b0;
      e_fre[k] = 1'b0;
      e_dre[k] = 1'b0;
      if (oo >= 0 && nedge == m_gedge[k] + 1) begin
        e_cen[k]   = 1'b1;
        e_caddr[k] = m_addr[k][oo];
        e_cmode[k] = (oo == 1) ? m_mode[k] : 1'b0;
        e_cwd[k]   = (oo == 1) ? m_wd[k] : '0;
        e_cws[k]   = (oo == 1) ? m_ws[k] : '0;
        m_last[k]  = (oo == 1);
      end
      if (oo >= 0 && nedge >= m_gedge[k] + 2 && cr_en[k]) begin
        if (oo == 1) begin
          e_dre[k] = 1'b1;
          e_drd[k] = cr_data[k];
        end else begin
          e_fre[k] = 1'b1;
          e_frd[k] = cr_data[k];
        end
        m_pend[k][oo] = 1'b0;
        m_own[k] = -1;
      end
      if (oo < 0 && (po0 || po1)) begin
        if (po0 && po1)
          m_own[k] = (k == 0) ? (m_last[k] ? 0 : 1) : 1;
        else
          m_own[k] = po1 ? 1 : 0;
        m_gedge[k] = nedge;
      end
      if (f_en && !po0) begin
        m_pend[k][0] = 1'b1;
        m_addr[k][0] = f_addr;
      end
      if (d_en && !po1) begin
        m_pend[k][1] = 1'b1;
        m_addr[k][1] = d_addr;
        m_mode[k]    = d_mode;
        m_wd[k]      = d_wdata;
        m_ws[k]      = d_wstrb;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    pfx[0] = "rr";
    pfx[1] = "fp";
    cen_cnt[0] = 0;
    cen_cnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (a_cen[k] === 1'b1) cen_cnt[k]++;
        check({pfx[k], "_c_en"}, 32'(a_cen[k]), 32'(e_cen[k]));
        check({pfx[k], "_c_mode"}, 32'(a_cmode[k]), 32'(e_cmode[k]));
        check({pfx[k], "_c_addr"}, a_caddr[k], e_caddr[k]);
        check({pfx[k], "_c_wdata"}, a_cwd[k], e_cwd[k]);
        check({pfx[k], "_c_wstrb"}, 32'(a_cws[k]), 32'(e_cws[k]));
        check({pfx[k], "_f_rsp"}, 32'(a_fre[k]), 32'(e_fre[k]));
        check({pfx[k], "_f_data"}, a_frd[k], e_frd[k]);
        check({pfx[k], "_d_rsp"}, 32'(a_dre[k]), 32'(e_dre[k]));
        check({pfx[k], "_d_data"}, a_drd[k], e_drd[k]);
      end
    end
  end

  // ---------------- directed helpers ----------------
  function automatic logic sig(input int k, input int w);
    case (w)
      0:       return a_cen[k];
      1:       return a_fre[k];
      default: return a_dre[k];
    endcase
  endfunction

  task automatic wait_hi(input int k, input int w, input int maxc,
                         output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (sig(k, w) === 1'b1) return;
      if (cyc >= maxc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL timeout_%s_sig%0d: got none in %0d cycles",
                 pfx[k], w, maxc);
        cyc = -1;
        return;
      end
    end
  endtask

  task automatic pulse_f(input logic [31:0] a);
    f_en   = 1'b1;
    f_addr = a;
    @(negedge clk);
    f_en = 1'b0;
  endtask

  task automatic pulse_d(input logic m, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
    d_en    = 1'b1;
    d_mode  = m;
    d_addr  = a;
    d_wdata = wd;
    d_wstrb = ws;
    @(negedge clk);
    d_en = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rstn = 1'b0;
    @(posedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int c0;
    int nf, nd, rep, prev, first, nresp;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check({pfx[k], "_rst_c_en"}, 32'(a_cen[k]), 32'd0);
      check({pfx[k], "_rst_c_addr"}, a_caddr[k], 32'd0);
      check({pfx[k], "_rst_f_data"}, a_frd[k], 32'd0);
    end
    @(posedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);

    // single fetch
    fix_rdata = 32'hDEADBEEF;
    pulse_f(32'h0000_1000);
    wait_hi(0, 0, 10, cyc);
    check("f_issue_lat", cyc, 2);
    check("f_c_addr", a_caddr[0], 32'h0000_1000);
    check("f_c_mode", 32'(a_cmode[0]), 32'd0);
    wait_hi(0, 1, 12, cyc);
    check("f_rsp_lat", cyc, 4);
    check("f_rsp_data", a_frd[0], 32'hDEADBEEF);
    check("f_rsp_data_fp", a_frd[1], 32'hDEADBEEF);
    check("f_no_d_rsp", 32'(a_dre[0]), 32'd0);

    // data write
    fix_rdata = 32'hCAFE0001;
    pulse_d(1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0011);
    wait_hi(0, 0, 10, cyc);
    check("w_c_addr", a_caddr[0], 32'h0000_2004);
    check("w_c_mode", 32'(a_cmode[0]), 32'd1);
    check("w_c_wdata", a_cwd[0], 32'h1234_5678);
    check("w_c_wstrb", 32'(a_cws[0]), 32'h3);
    wait_hi(0, 2, 12, cyc);
    check("w_rsp_data", a_drd[0], 32'hCAFE0001);
    check("w_no_f_rsp", 32'(a_fre[0]), 32'd0);

    // simultaneous requests after reset
    do_reset();
    fix_rdata = 32'h5A5A_0003;
    c0 = cen_cnt[0];
    f_en   = 1'b1;
    f_addr = 32'h100;
    d_en   = 1'b1;
    d_mode = 1'b0;
    d_addr = 32'h200;
    d_wdata = '0;
    d_wstrb = '0;
    @(negedge clk);
    f_en = 1'b0;
    d_en = 1'b0;
    wait_hi(0, 0, 10, cyc);
    check("sim_rr_first", a_caddr[0], 32'h100);
    check("sim_fp_first", a_caddr[1], 32'h200);
    idle(30);
    check("sim_rr_pulses", cen_cnt[0] - c0, 2);
    check("sim_rr_second", a_caddr[0], 32'h200);
    check("sim_rr_f_data", a_frd[0], 32'h5A5A_0003);

    // fixed priority under constant re-request
    nf = 0; nd = 0; rep = 0; prev = -1; first = -1;
    f_addr = 32'hF000;
    d_addr = 32'hD000;
    for (int i = 0; i < 60; i++) begin
      f_en = 1'b1;
      d_en = 1'b1;
      @(negedge clk);
      if (a_cen[1] === 1'b1) begin
        if (a_caddr[1] == 32'hD000) begin
          nd++;
          if (prev == 1) rep++;
          if (first < 0) first = 1;
          prev = 1;
        end else begin
          nf++;
          if (prev == 0) rep++;
          if (first < 0) first = 0;
          prev = 0;
        end
      end
    end
    f_en = 1'b0;
    d_en = 1'b0;
    idle(30);
    check("fp_first_data", first, 1);
    check("fp_alternate", rep, 0);
    check("fp_enough_d", 32'(nd >= 4), 32'd1);
    check("fp_enough_f", 32'(nf >= 4), 32'd1);

    // duplicate data request while waiting
    cdelay = 4;
    c0 = cen_cnt[0];
    pulse_d(1'b0, 32'h200, 32'h0, 4'h0);
    wait_hi(0, 0, 10, cyc);
    check("dup_c_addr", a_caddr[0], 32'h200);
    pulse_d(1'b0, 32'h300, 32'h0, 4'h0);
    wait_hi(0, 2, 12, cyc);
    idle(10);
    check("dup_pulses", cen_cnt[0] - c0, 1);
    check("dup_addr_held", a_caddr[0], 32'h200);

    // reset while waiting, stale response afterwards
    pulse_f(32'h400);
    wait_hi(0, 0, 10, cyc);
    @(posedge clk);
    #2 rstn = 1'b0;
    @(negedge clk);
    check("rw_c_addr", a_caddr[0], 32'd0);
    check("rw_f_data", a_frd[0], 32'd0);
    check("rw_d_data", a_drd[0], 32'd0);
    @(posedge clk);
    #2 rstn = 1'b1;
    nresp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_fre[0] === 1'b1 || a_dre[0] === 1'b1) nresp++;
    end
    check("rw_stale_ignored", nresp, 0);
    cdelay = 3;
    fix_rdata = 32'h0BAD_F00D;
    pulse_f(32'h500);
    wait_hi(0, 1, 16, cyc);
    check("rw_new_fetch", a_frd[0], 32'h0BAD_F00D);

    // randomized traffic with stray cache pulses
    cdelay = 0;
    stray_en = 1'b1;
    fix_data = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      f_en    = ($urandom_range(2, 0) == 0);
      f_addr  = $urandom;
      d_en    = ($urandom_range(2, 0) == 0);
      d_mode  = $urandom_range(1, 0) == 1;
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_wstrb = 4'($urandom_range(15, 0));
      @(negedge clk);
    end
    f_en = 1'b0;
    d_en = 1'b0;
    stray_en = 1'b0;
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
